byte_queue: RTL and testbench

//  Byte FIFO directly downstream of the serial-to-byte deserializer. Accepts its

---
 rtl/byte_queue.sv | 126 ++++++++++++
 tb/tb_byte_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_queue.sv
// Byte FIFO fed by the deserializer over a 4-phase req/ack handshake and drained
// one entry per dequeue request; everything runs on clock_10KHZ.
`timescale 1ns/1ps

module byte_queue #(
    parameter int DEPTH       = 8,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clock_10KHZ,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         data_ready_in,
    output logic                         ack_out,
    input  logic                         dequeue_in,
    output logic [WIDTH-1:0]             data_out,
    output logic                         data_valid_out,
    output logic [$clog2(DEPTH+1)-1:0]   len_out,
    output logic                         full_out,
    output logic                         empty_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DEPTH);

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   do_write;
    logic                   do_read;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LEN_W-1:0]       len_next;
    logic [WIDTH-1:0]       mem [DEPTH];

    // data_in is stable for the whole request, so only the request level is synchronised.
    always_ff @(posedge clock_10KHZ or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data_ready_in};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock_10KHZ or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: defaults first so no path through always_comb leaves a signal unassigned (no latches).
    always_comb begin
        next_state = state;
        do_write   = 1'b0;
        case (state)
            IDLE: begin
                if (req_s && !full_out) begin
                    do_write   = 1'b1;
                    next_state = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign ack_out = (state == ACK);
    assign do_read = dequeue_in && !empty_out;

    // Both sides act on the pre-edge occupancy, so a full queue pops first and an empty one writes first.
    always_comb begin
        len_next = len_out;
        case ({do_write, do_read})
            2'b10:   len_next = len_out + LEN_W'(1);
            2'b01:   len_next = len_out - LEN_W'(1);
            default: len_next = len_out;
        endcase
    end

    always_ff @(posedge clock_10KHZ or negedge reset) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            len_out        <= '0;
            full_out       <= 1'b0;
            empty_out      <= 1'b1;
            data_out       <= '0;
            data_valid_out <= 1'b0;
        end else begin
            len_out        <= len_next;
            full_out       <= (len_next == FULL_LEN);
            empty_out      <= (len_next == '0);
            data_valid_out <= do_read;
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                data_out <= mem[rd_ptr];
            end
        end
    end

    // NOTE: the storage array has no reset; its contents only matter once written.
    always_ff @(posedge clock_10KHZ) begin
        if (do_write) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_byte_queue.sv
// Self-checking bench for byte_queue: handshake timing, occupancy flags and a
// scoreboard that checks every popped byte against the order it was offered.
`timescale 1ns/1ps

module tb_byte_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = '0;
    logic       data_ready_in = 1'b0;
    logic       ack_out;
    logic       dequeue_in = 1'b0;
    logic [7:0] data_out;
    logic       data_valid_out;
    logic [3:0] len_out;
    logic       full_out;
    logic       empty_out;

    int         checks = 0;
    int         failures = 0;
    int         pulses = 0;
    logic [7:0] exp_q[$];

    byte_queue #(.DEPTH(8), .WIDTH(8), .SYNC_STAGES(2)) dut (
        .clock_10KHZ    (clk),
        .reset          (rst_n),
        .data_in        (data_in),
        .data_ready_in  (data_ready_in),
        .ack_out        (ack_out),
        .dequeue_in     (dequeue_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .len_out        (len_out),
        .full_out       (full_out),
        .empty_out      (empty_out)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every output pulse must carry the oldest outstanding byte.
    always @(negedge clk) begin
        if (rst_n && data_valid_out) begin
            logic [7:0] exp_b;
            pulses++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pop", 32'(data_out), 32'hFFFF);
            end else begin
                exp_b = exp_q.pop_front();
                check("sb_data", 32'(data_out), 32'(exp_b));
            end
        end
    end

    task automatic wait_ack(input logic level, input string tag);
        int n = 0;
        while (ack_out !== level && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(ack_out), 32'(level));
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_in       = b;
        data_ready_in = 1'b1;
        exp_q.push_back(b);
        wait_ack(1'b1, "ack_rise");
        data_ready_in = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic drain();
        int n = 0;
        dequeue_in = 1'b1;
        while (!empty_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        dequeue_in = 1'b0;
        check("drain_empty", 32'(empty_out), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ack"},   32'(ack_out),        32'd0);
        check({tag, "_data"},  32'(data_out),       32'd0);
        check({tag, "_valid"}, 32'(data_valid_out), 32'd0);
        check({tag, "_len"},   32'(len_out),        32'd0);
        check({tag, "_full"},  32'(full_out),       32'd0);
        check({tag, "_empty"}, 32'(empty_out),      32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst_n = 1'b1;
        @(negedge clk);

        // T1: reset in the middle of an acknowledged handshake with three entries stored
        send_byte(8'h11);
        send_byte(8'h22);
        data_in       = 8'h33;
        data_ready_in = 1'b1;
        exp_q.push_back(8'h33);
        wait_ack(1'b1, "t1_ack_rise");
        check("t1_len3", 32'(len_out), 32'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("t1_rst");
        data_ready_in = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h3C);
        check("t1_len_after", 32'(len_out), 32'd1);
        drain();

        // T2: long request yields a single entry; ack timing on both edges
        data_in       = 8'hA5;
        data_ready_in = 1'b1;
        exp_q.push_back(8'hA5);
        repeat (2) @(negedge clk);
        check("t2_ack_edge2", 32'(ack_out), 32'd0);
        @(negedge clk);
        check("t2_ack_edge3", 32'(ack_out), 32'd1);
        repeat (20) @(negedge clk);
        check("t2_len_nodup", 32'(len_out), 32'd1);
        check("t2_ack_held", 32'(ack_out), 32'd1);
        data_ready_in = 1'b0;
        repeat (2) @(negedge clk);
        check("t2_ack_hold2", 32'(ack_out), 32'd1);
        @(negedge clk);
        check("t2_ack_drop3", 32'(ack_out), 32'd0);
        drain();

        // T3: fill to DEPTH, ninth request waits for a pop
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        check("t3_full", 32'(full_out), 32'd1);
        check("t3_len8", 32'(len_out), 32'd8);
        data_in       = 8'h09;
        data_ready_in = 1'b1;
        exp_q.push_back(8'h09);
        repeat (6) @(negedge clk);
        check("t3_ack_blocked", 32'(ack_out), 32'd0);
        check("t3_len_blocked", 32'(len_out), 32'd8);
        dequeue_in = 1'b1;
        @(negedge clk);
        dequeue_in = 1'b0;
        check("t3_pop_data", 32'(data_out), 32'h01);
        check("t3_pop_valid", 32'(data_valid_out), 32'd1);
        check("t3_pop_len", 32'(len_out), 32'd7);
        check("t3_pop_ack", 32'(ack_out), 32'd0);
        @(negedge clk);
        check("t3_late_ack", 32'(ack_out), 32'd1);
        check("t3_late_len", 32'(len_out), 32'd8);
        check("t3_late_full", 32'(full_out), 32'd1);
        data_ready_in = 1'b0;
        wait_ack(1'b0, "t3_ack_fall");
        drain();

        // T4: dequeue held high on three bytes
        pulses = 0;
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        dequeue_in = 1'b1;
        repeat (6) @(negedge clk);
        dequeue_in = 1'b0;
        check("t4_pulses", 32'(pulses), 32'd3);
        check("t4_empty", 32'(empty_out), 32'd1);
        check("t4_hold", 32'(data_out), 32'hC3);
        check("t4_no_pulse", 32'(data_valid_out), 32'd0);
        check("t4_len0", 32'(len_out), 32'd0);

        // T5: twenty bytes through the ring, pointers wrap
        pulses = 0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 5; j++) send_byte(8'(8'h40 + 5 * r + j));
            drain();
        end
        check("t5_pulses", 32'(pulses), 32'd20);

        // T6a: simultaneous write and pop at len=4
        for (int i = 0; i < 4; i++) send_byte(8'(8'hD0 + i));
        data_in       = 8'hE4;
        data_ready_in = 1'b1;
        exp_q.push_back(8'hE4);
        repeat (2) @(negedge clk);
        dequeue_in = 1'b1;
        @(negedge clk);
        dequeue_in = 1'b0;
        check("t6a_len", 32'(len_out), 32'd4);
        check("t6a_ack", 32'(ack_out), 32'd1);
        check("t6a_valid", 32'(data_valid_out), 32'd1);
        data_ready_in = 1'b0;
        wait_ack(1'b0, "t6a_ack_fall");
        drain();

        // T6b: simultaneous write and pop on an empty queue
        pulses = 0;
        data_in       = 8'hF0;
        data_ready_in = 1'b1;
        exp_q.push_back(8'hF0);
        repeat (2) @(negedge clk);
        dequeue_in = 1'b1;
        @(negedge clk);
        dequeue_in = 1'b0;
        check("t6b_len", 32'(len_out), 32'd1);
        check("t6b_valid", 32'(data_valid_out), 32'd0);
        check("t6b_ack", 32'(ack_out), 32'd1);
        check("t6b_empty", 32'(empty_out), 32'd0);
        data_ready_in = 1'b0;
        wait_ack(1'b0, "t6b_ack_fall");
        check("t6b_pulses", 32'(pulses), 32'd0);

        // T6c: simultaneous write and pop on a full queue
        for (int i = 0; i < 7; i++) send_byte(8'(8'h70 + i));
        check("t6c_full", 32'(full_out), 32'd1);
        data_in       = 8'h5A;
        data_ready_in = 1'b1;
        exp_q.push_back(8'h5A);
        repeat (2) @(negedge clk);
        dequeue_in = 1'b1;
        @(negedge clk);
        dequeue_in = 1'b0;
        check("t6c_len7", 32'(len_out), 32'd7);
        check("t6c_ack0", 32'(ack_out), 32'd0);
        check("t6c_valid", 32'(data_valid_out), 32'd1);
        @(negedge clk);
        check("t6c_len8", 32'(len_out), 32'd8);
        check("t6c_ack1", 32'(ack_out), 32'd1);
        data_ready_in = 1'b0;
        wait_ack(1'b0, "t6c_ack_fall");
        drain();
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
